stat_scheduler: RTL and testbench

- Sequences the three 6-bit stat registers driven to the display path (value1..value3) from the three user switches and the presence sensor.
- Periodically decays all stats, serves switch requests one at a time with round-robin arbitration, and pauses while the sensor is active.
- Instantiated inside top between the switch inputs and the display/value datapath.

---
 rtl/stat_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_stat_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_scheduler.sv
// Stat scheduler: decays three 6-bit stats on a prescaled tick and serves switch requests round-robin.
// Optional macro SLEEP_SENSOR_EN enables the SLEEP state driven by the presence sensor.
module stat_scheduler #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter logic [5:0]  STEP     = 6'd4,
  parameter logic [5:0]  DECAY    = 6'd1,
  parameter logic [5:0]  INIT     = 6'd32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       sw3,
  input  logic       sensor,
  output logic [5:0] value1,
  output logic [5:0] value2,
  output logic [5:0] value3,
  output logic [2:0] grant,
  output logic [1:0] state,
  output logic       alarm
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DECAY = 2'd1,
    ST_SERVE = 2'd2,
    ST_SLEEP = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           tick_q, tick_d;
  logic [2:0]     pending_q, pending_d;
  logic [2:0]     sw_q, sw_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [5:0]     val_q [3];
  logic [5:0]     val_d [3];
  logic [2:0]     grant_q, grant_d;
  logic           alarm_q, alarm_d;

  logic [2:0]     rise, clr, rest;
  logic [1:0]     gidx, cand;
  logic           gfound;
  logic           sleep_req;

`ifdef SLEEP_SENSOR_EN
  assign sleep_req = sensor;
`else
  logic unused_sensor;
  assign unused_sensor = sensor;
  assign sleep_req     = 1'b0;
`endif

  function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [5:0] b);
    logic [6:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[6] ? 6'd63 : s[5:0];
  endfunction

  function automatic logic [5:0] sat_sub(input logic [5:0] a, input logic [5:0] b);
    logic [6:0] s;
    s = {1'b0, a} - {1'b0, b};
    return s[6] ? 6'd0 : s[5:0];
  endfunction

  function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= 3) s = s - 3;
    return 2'(s);
  endfunction

  // Round-robin pick: scan from farthest to nearest so the nearest pending bit wins.
  always_comb begin
    gidx   = 2'd0;
    gfound = 1'b0;
    cand   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = rr_idx(ptr_q, k);
      if (pending_q[cand]) begin
        gidx   = cand;
        gfound = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = tick_q;
    ptr_d   = ptr_q;
    grant_d = 3'b000;
    clr     = 3'b000;
    sw_d    = {sw3, sw2, sw1};
    rise    = sw_d & ~sw_q;
    for (int k = 0; k < 3; k++) val_d[k] = val_q[k];

    case (state_q)
      ST_DECAY: begin
        for (int k = 0; k < 3; k++) val_d[k] = sat_sub(val_q[k], DECAY);
        tick_d = 1'b0;
      end
      ST_SERVE: begin
        if (gfound) begin
          clr[gidx]     = 1'b1;
          grant_d[gidx] = 1'b1;
          val_d[gidx]   = sat_add(val_q[gidx], STEP);
          ptr_d         = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
        end
      end
      default: ;
    endcase

    // A tick landing on the DECAY cycle must survive the clear to keep the period exact.
    if (state_q != ST_SLEEP) begin
      if (presc_q == LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    rest      = pending_q & ~clr;
    pending_d = rest | rise;

    case (state_q)
      ST_IDLE: begin
        if (sleep_req)              state_d = ST_SLEEP;
        else if (tick_q)            state_d = ST_DECAY;
        else if (pending_q != 3'b0) state_d = ST_SERVE;
      end
      ST_DECAY: begin
        if (sleep_req)              state_d = ST_SLEEP;
        else if (tick_d)            state_d = ST_DECAY;
        else if (pending_q != 3'b0) state_d = ST_SERVE;
        else                        state_d = ST_IDLE;
      end
      ST_SERVE: begin
        if (sleep_req)         state_d = ST_SLEEP;
        else if (tick_q)       state_d = ST_DECAY;
        else if (rest != 3'b0) state_d = ST_SERVE;
        else                   state_d = ST_IDLE;
      end
      default: begin
        if (!sleep_req) state_d = ST_IDLE;
      end
    endcase

    alarm_d = (val_d[0] == 6'd0) || (val_d[1] == 6'd0) || (val_d[2] == 6'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      pending_q <= 3'b000;
      sw_q      <= 3'b000;
      ptr_q     <= 2'd0;
      grant_q   <= 3'b000;
      alarm_q   <= 1'b0;
      for (int k = 0; k < 3; k++) val_q[k] <= INIT;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
      sw_q      <= sw_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      alarm_q   <= alarm_d;
      for (int k = 0; k < 3; k++) val_q[k] <= val_d[k];
    end
  end

  assign value1 = val_q[0];
  assign value2 = val_q[1];
  assign value3 = val_q[2];
  assign grant  = grant_q;
  assign state  = state_q;
  assign alarm  = alarm_q;

endmodule

// File: tb/tb_stat_scheduler.sv
// Bench for stat_scheduler: slow-tick instance for request scoreboarding, fast-tick instance for decay/sleep.
module tb_stat_scheduler;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [2:0] sw_a, sw_b;
  logic       sensor_a, sensor_b;
  logic [5:0] va1, va2, va3, vb1, vb2, vb3;
  logic [2:0] grant_a, grant_b;
  logic [1:0] state_a, state_b;
  logic       alarm_a, alarm_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stat_scheduler #(.TICK_DIV(1000)) dut_a (
    .clk(clk), .rst(rst_a), .sw1(sw_a[0]), .sw2(sw_a[1]), .sw3(sw_a[2]),
    .sensor(sensor_a), .value1(va1), .value2(va2), .value3(va3),
    .grant(grant_a), .state(state_a), .alarm(alarm_a)
  );

  stat_scheduler #(.TICK_DIV(8)) dut_b (
    .clk(clk), .rst(rst_b), .sw1(sw_b[0]), .sw2(sw_b[1]), .sw3(sw_b[2]),
    .sensor(sensor_b), .value1(vb1), .value2(vb2), .value3(vb3),
    .grant(grant_b), .state(state_b), .alarm(alarm_b)
  );

  typedef struct {
    logic [2:0] g;
    logic [5:0] v;
  } exp_t;

  typedef struct {
    logic [2:0] sw;
    int         n;
    int         o0;
    int         o1;
    int         o2;
  } vec_t;

  exp_t sbq[$];
  int   model[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic [5:0] sel_val(input logic [2:0] g);
    case (g)
      3'b001:  return va1;
      3'b010:  return va2;
      3'b100:  return va3;
      default: return 6'h3f;
    endcase
  endfunction

  task automatic push_req(input int idx);
    exp_t e;
    model[idx] = (model[idx] + 4 > 63) ? 63 : model[idx] + 4;
    e.g = 3'b001 << idx;
    e.v = 6'(model[idx]);
    sbq.push_back(e);
  endtask

  // Scoreboard monitor for dut_a: every grant pulse consumes one expected entry.
  always @(negedge clk) begin
    if (grant_a !== 3'b000) begin
      if (sbq.size() == 0) begin
        chk("unexpected_grant", {29'd0, grant_a}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_grant", {29'd0, grant_a}, {29'd0, e.g});
        chk("sb_value", {26'd0, sel_val(grant_a)}, {26'd0, e.v});
      end
    end
  end

  task automatic reset_a();
    rst_a = 1'b1;
    sw_a  = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    sbq.delete();
    for (int k = 0; k < 3; k++) model[k] = 32;
  endtask

  task automatic reset_b(input logic sens);
    rst_b    = 1'b1;
    sw_b     = 3'b000;
    sensor_b = sens;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  vec_t vecs[7];
  int   n;
  logic [5:0] frz;

  initial begin
    vecs[0] = '{3'b111, 3, 0, 1, 2};
    vecs[1] = '{3'b111, 3, 0, 1, 2};
    vecs[2] = '{3'b110, 2, 1, 2, 0};
    vecs[3] = '{3'b101, 2, 0, 2, 0};
    vecs[4] = '{3'b011, 2, 0, 1, 0};
    vecs[5] = '{3'b101, 2, 2, 0, 0};
    vecs[6] = '{3'b111, 3, 1, 2, 0};

    rst_a = 1'b1; rst_b = 1'b1; sw_a = 3'b000; sw_b = 3'b000;
    sensor_a = 1'b0; sensor_b = 1'b0;
    for (int k = 0; k < 3; k++) model[k] = 32;

    // Reset state
    rst_b = 1'b1;
    reset_a();
    rst_b = 1'b0;
    chk("rst_v1", {26'd0, va1}, 32);
    chk("rst_v2", {26'd0, va2}, 32);
    chk("rst_v3", {26'd0, va3}, 32);
    chk("rst_state", {30'd0, state_a}, 0);
    chk("rst_grant", {29'd0, grant_a}, 0);
    chk("rst_alarm", {31'd0, alarm_a}, 0);
    chk("rst_b_v1", {26'd0, vb1}, 32);

    // Single request, held switch
    sw_a = 3'b001;
    push_req(0);
    @(negedge clk); chk("lat_e1", {26'd0, va1}, 32);
    @(negedge clk); chk("lat_e2", {26'd0, va1}, 32);
    @(negedge clk); chk("lat_e3", {26'd0, va1}, 36);
    chk("lat_grant", {29'd0, grant_a}, 3'b001);
    @(negedge clk); chk("grant_pulse", {29'd0, grant_a}, 0);
    repeat (6) @(negedge clk);
    chk("held_v1", {26'd0, va1}, 36);
    chk("held_q", sbq.size(), 0);
    sw_a = 3'b000;

    // Round-robin table
    reset_a();
    for (int i = 0; i < 7; i++) begin
      int ord[3];
      ord[0] = vecs[i].o0; ord[1] = vecs[i].o1; ord[2] = vecs[i].o2;
      sw_a = vecs[i].sw;
      for (int j = 0; j < vecs[i].n; j++) push_req(ord[j]);
      repeat (2) @(negedge clk);
      for (int j = 0; j < vecs[i].n; j++) begin
        @(negedge clk);
        chk($sformatf("rr_v%0d_g%0d", i, j), {29'd0, grant_a}, {29'd0, 3'b001 << ord[j]});
      end
      sw_a = 3'b000;
      repeat (3) @(negedge clk);
      chk($sformatf("rr_v%0d_drain", i), sbq.size(), 0);
    end
    chk("rr_v1", {26'd0, va1}, 56);
    chk("rr_v2", {26'd0, va2}, 52);
    chk("rr_v3", {26'd0, va3}, 56);

    // Saturation at 63
    reset_a();
    repeat (2100) @(negedge clk);
    chk("two_ticks_v1", {26'd0, va1}, 30);
    chk("two_ticks_v2", {26'd0, va2}, 30);
    for (int k = 0; k < 3; k++) model[k] = 30;
    for (int i = 0; i < 9; i++) begin
      push_req(0);
      sw_a = 3'b001;
      repeat (4) @(negedge clk);
      sw_a = 3'b000;
      repeat (2) @(negedge clk);
    end
    chk("sat_v1", {26'd0, va1}, 63);
    chk("sat_drain", sbq.size(), 0);

    // Decay to zero and alarm
    reset_b(1'b0);
    n = 0;
    while (vb1 == 6'd32 && n < 20) begin @(negedge clk); n++; end
    chk("decay_first", {26'd0, vb1}, 31);
    repeat (7) @(negedge clk);
    chk("decay_hold", {26'd0, vb1}, 31);
    @(negedge clk);
    chk("decay_step_v1", {26'd0, vb1}, 30);
    chk("decay_step_v3", {26'd0, vb3}, 30);
    repeat (239) @(negedge clk);
    chk("decay_one", {26'd0, vb1}, 1);
    chk("alarm_low", {31'd0, alarm_b}, 0);
    @(negedge clk);
    chk("decay_zero_v1", {26'd0, vb1}, 0);
    chk("decay_zero_v2", {26'd0, vb2}, 0);
    chk("alarm_high", {31'd0, alarm_b}, 1);
    repeat (24) @(negedge clk);
    chk("zero_hold", {26'd0, vb3}, 0);
    chk("alarm_hold", {31'd0, alarm_b}, 1);

    // Tick and request in the same cycle: DECAY first, then SERVE
    reset_b(1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    sw_b = 3'b001;
    @(negedge clk); chk("prio_idle", {30'd0, state_b}, 0);
    @(negedge clk); chk("prio_decay", {30'd0, state_b}, 1);
    @(negedge clk); chk("prio_serve", {30'd0, state_b}, 2);
    chk("prio_dec_v1", {26'd0, vb1}, 31);
    @(negedge clk);
    chk("prio_v1", {26'd0, vb1}, 35);
    chk("prio_grant", {29'd0, grant_b}, 3'b001);
    sw_b = 3'b000;

`ifdef SLEEP_SENSOR_EN
    reset_b(1'b1);
    repeat (2) @(negedge clk);
    chk("sleep_state", {30'd0, state_b}, 3);
    repeat (24) @(negedge clk);
    chk("sleep_v1", {26'd0, vb1}, 32);
    chk("sleep_v2", {26'd0, vb2}, 32);
    sw_b = 3'b010;
    repeat (2) @(negedge clk);
    sensor_b = 1'b0;
    n = 0;
    while (grant_b !== 3'b010 && n < 10) begin @(negedge clk); n++; end
    chk("wake_grant", {29'd0, grant_b}, 3'b010);
    chk("wake_v2", {26'd0, vb2}, 36);
    chk("wake_v1", {26'd0, vb1}, 32);
    sw_b = 3'b000;
`else
    reset_b(1'b1);
    repeat (2) @(negedge clk);
    chk("nosleep_state", {31'd0, state_b == 2'd3}, 0);
    frz = vb1;
    n = 0;
    while (vb1 == frz && n < 20) begin @(negedge clk); n++; end
    chk("nosleep_decay", {26'd0, vb1}, 31);
    sensor_b = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
